// File: rtl/dac_spi_tx_if.sv
// Host/DAC side signals of the DAC SPI transmitter.
//   slave  : the transmitter (takes frame writes and LDAC requests, drives the DAC pins and status)
//   master : the frame source / observer (FSMC write decoder, or the testbench)
// Signals:
//   wr_en, wr_data[23:0]  one-cycle frame push
//   ldac_req              one-cycle LDAC request
//   clr_ovf               clears the sticky overflow flag
//   SYNC, SCLK, SDIN, LDAC  DAC pins (SYNC/LDAC active low, SCLK idles high)
//   full, empty, busy, overflow, frame_done  status
interface dac_spi_tx_if;
  logic        wr_en;
  logic [23:0] wr_data;
  logic        ldac_req;
  logic        clr_ovf;
  logic        SYNC;
  logic        SCLK;
  logic        SDIN;
  logic        LDAC;
  logic        full;
  logic        empty;
  logic        busy;
  logic        overflow;
  logic        frame_done;

  modport slave (
    input  wr_en, wr_data, ldac_req, clr_ovf,
    output SYNC, SCLK, SDIN, LDAC, full, empty, busy, overflow, frame_done
  );

  modport master (
    output wr_en, wr_data, ldac_req, clr_ovf,
    input  SYNC, SCLK, SDIN, LDAC, full, empty, busy, overflow, frame_done
  );
endinterface

// File: rtl/dac_spi_tx.sv
// SPI master for the AD5384/AD5394 DAC. Frames written by the host are
// queued in a small FIFO and shifted out MSB-first under SYNC; an LDAC
// request produces one LDAC low pulse once every queued frame has gone out.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   bus    dac_spi_tx_if.slave (frame writes in, DAC pins and status out)
module dac_spi_tx #(
  parameter int CLK_DIV    = 2,  // SCLK half-period in clk cycles
  parameter int GAP_CYCLES = 4,  // minimum SYNC-high time between frames
  parameter int LDAC_WIDTH = 3,  // LDAC low-pulse width
  parameter int FIFO_DEPTH = 4   // frame slots, power of two
) (
  input  logic        clk,
  input  logic        reset,
  dac_spi_tx_if.slave bus
);
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TMAX = (GAP_CYCLES > LDAC_WIDTH) ? GAP_CYCLES : LDAC_WIDTH;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_LDAC  = 3'd4;

  logic [23:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic [2:0]    r_state;
  logic [22:0]   r_shreg;   // bits still to send after the one on SDIN
  logic [4:0]    r_bit;
  logic [DW-1:0] r_div;
  logic [TW-1:0] r_tmr;
  logic          r_sync, r_sclk, r_sdin, r_ldac, r_ovf, r_done, r_pend;

  logic w_full, w_empty, w_push, w_pop, w_div_end;

  function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  // A write while full is dropped even if a pop frees a slot this cycle.
  assign w_push    = bus.wr_en && !w_full;
  assign w_pop     = (r_state == S_IDLE) && !w_empty;
  assign w_div_end = (r_div == DW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= f_inc(r_wptr);
      if (w_pop)  r_rptr <= f_inc(r_rptr);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      // Set beats clear when both land in the same cycle.
      if (bus.wr_en && w_full) r_ovf <= 1'b1;
      else if (bus.clr_ovf)    r_ovf <= 1'b0;
      // Requests during the pulse are absorbed into it.
      if (r_state == S_LDAC && r_tmr == TW'(LDAC_WIDTH - 1)) r_pend <= 1'b0;
      else if (bus.ldac_req && r_state != S_LDAC)            r_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_bit   <= '0;
      r_div   <= '0;
      r_tmr   <= '0;
      r_sync  <= 1'b1;
      r_sclk  <= 1'b1;
      r_sdin  <= 1'b0;
      r_ldac  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        // IDLE is only ever reached through GAP, LDAC_PULSE or reset, so the
        // inter-frame gap is already satisfied here. Frames beat LDAC.
        S_IDLE: begin
          if (!w_empty) begin
            r_shreg <= r_mem[r_rptr][22:0];
            r_sdin  <= r_mem[r_rptr][23];
            r_sync  <= 1'b0;
            r_div   <= '0;
            r_state <= S_SETUP;
          end else if (r_pend) begin
            r_ldac  <= 1'b0;
            r_tmr   <= '0;
            r_state <= S_LDAC;
          end
        end
        S_SETUP: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_sclk  <= 1'b0;
            r_bit   <= 5'd23;
            r_state <= S_SHIFT;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        // SCLK low half then high half per bit; SDIN moves on the rising edge
        // so it is stable a full half-period around every falling edge.
        S_SHIFT: begin
          if (!w_div_end) begin
            r_div <= r_div + 1'b1;
          end else begin
            r_div <= '0;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
              if (r_bit != 5'd0) begin
                r_sdin  <= r_shreg[22];
                r_shreg <= {r_shreg[21:0], 1'b0};
              end
            end else if (r_bit == 5'd0) begin
              r_sync  <= 1'b1;
              r_sdin  <= 1'b0;
              r_done  <= 1'b1;
              r_tmr   <= '0;
              r_state <= S_GAP;
            end else begin
              r_sclk <= 1'b0;
              r_bit  <= r_bit - 5'd1;
            end
          end
        end
        S_GAP: begin
          if (r_tmr == TW'(GAP_CYCLES - 1)) r_state <= S_IDLE;
          else                              r_tmr   <= r_tmr + 1'b1;
        end
        S_LDAC: begin
          if (r_tmr == TW'(LDAC_WIDTH - 1)) begin
            r_ldac  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.SYNC       = r_sync;
  assign bus.SCLK       = r_sclk;
  assign bus.SDIN       = r_sdin;
  assign bus.LDAC       = r_ldac;
  assign bus.full       = w_full;
  assign bus.empty      = w_empty;
  assign bus.overflow   = r_ovf;
  assign bus.frame_done = r_done;
  assign bus.busy       = (r_state != S_IDLE) || r_pend;
endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: a default instance and a CLK_DIV=1/GAP_CYCLES=1
// instance share clock and reset. A pin-level monitor rebuilds each frame
// from SYNC/SCLK/SDIN; flag behaviour comes from a vector table, corner
// cases from hand sequences, and a random phase runs against a cycle-level
// FIFO/occupancy model.
module tb_dac_spi_tx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dac_spi_tx_if b0();
  dac_spi_tx_if b1();

  dac_spi_tx u0 (.clk(clk), .reset(reset), .bus(b0));
  dac_spi_tx #(.CLK_DIV(1), .GAP_CYCLES(1)) u1 (.clk(clk), .reset(reset), .bus(b1));

  // frame start-to-next-idle on the default instance: pop + 49*CLK_DIV + GAP
  localparam int PERIOD0 = 1 + 49 * 2 + 4;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- pin monitor ----------------
  typedef struct { logic [23:0] data; int nb; int low; int gap; bit fd; } frm_t;
  frm_t rxq0[$];
  frm_t rxq1[$];
  int cyc = 0;
  bit p_sync[2] = '{1'b1, 1'b1};
  bit p_sclk[2] = '{1'b1, 1'b1};
  bit p_ldac[2] = '{1'b1, 1'b1};
  logic [23:0] sh[2];
  int nb[2], low[2], rise_cyc[2], gapv[2], fd_cnt[2];
  int ldac_falls[2], ldac_fall_cyc[2], ldac_len[2], ldac_dly[2], ldac_viol[2];

  task automatic mon_step(input int g, input logic sy, input logic sc, input logic sd,
                          input logic fd, input logic ld);
    frm_t f;
    if (p_sync[g] && sy === 1'b0) begin
      sh[g] = '0; nb[g] = 0; low[g] = 0; gapv[g] = cyc - rise_cyc[g];
    end
    if (sy === 1'b0) begin
      low[g]++;
      if (p_sclk[g] && sc === 1'b0) begin
        sh[g] = {sh[g][22:0], sd};
        nb[g]++;
      end
    end
    if (!p_sync[g] && sy === 1'b1) begin
      f.data = sh[g]; f.nb = nb[g]; f.low = low[g]; f.gap = gapv[g]; f.fd = (fd === 1'b1);
      if (g == 0) rxq0.push_back(f); else rxq1.push_back(f);
      rise_cyc[g] = cyc;
    end
    if (fd === 1'b1) fd_cnt[g]++;
    if (p_ldac[g] && ld === 1'b0) begin
      ldac_falls[g]++; ldac_fall_cyc[g] = cyc; ldac_dly[g] = cyc - rise_cyc[g];
    end
    if (!p_ldac[g] && ld === 1'b1) ldac_len[g] = cyc - ldac_fall_cyc[g];
    if (ld === 1'b0 && sy !== 1'b1) ldac_viol[g]++;
    p_sync[g] = sy; p_sclk[g] = sc; p_ldac[g] = ld;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      mon_step(0, b0.SYNC, b0.SCLK, b0.SDIN, b0.frame_done, b0.LDAC);
      mon_step(1, b1.SYNC, b1.SCLK, b1.SDIN, b1.frame_done, b1.LDAC);
    end
  end

  // ---------------- helpers ----------------
  task automatic tick; @(posedge clk); #1; endtask
  task automatic smp;  @(negedge clk); #1; endtask

  task automatic wait_rx(input int g, input int n, input int budget);
    int k = 0;
    while (((g == 0) ? rxq0.size() : rxq1.size()) < n && k < budget) begin smp; k++; end
    chk("rx_count", (g == 0) ? rxq0.size() : rxq1.size(), n);
  endtask

  task automatic wait_idle0(input int budget);
    int k = 0;
    while (b0.busy !== 1'b0 && k < budget) begin smp; k++; end
    chk("idle_wait", b0.busy, 0);
  endtask

  task automatic chk_frame(input string nm, input frm_t f, input logic [23:0] d,
                           input int low_exp, input int gap_exp);
    chk({nm, "_data"}, f.data, d);
    chk({nm, "_falls"}, f.nb, 24);
    chk({nm, "_synclow"}, f.low, low_exp);
    chk({nm, "_done"}, f.fd, 1);
    if (gap_exp > 0) chk({nm, "_gap"}, f.gap, gap_exp);
  endtask

  typedef struct { bit wr; bit clr; logic [23:0] d; bit f; bit e; bit o; bit b; } vec_t;
  vec_t vec[11];

  initial begin
    int fd0, lf0, burst, mcnt, idle_at;
    bit movf;
    logic [23:0] expq[$];

    // wr, clr, data, then expected full/empty/overflow/busy one cycle later
    vec[0]  = '{1'b1, 1'b0, 24'h5A0001, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[1]  = '{1'b1, 1'b0, 24'h5A0102, 1'b0, 1'b0, 1'b0, 1'b1};  // push+pop: count stays 1
    vec[2]  = '{1'b1, 1'b0, 24'h5A0203, 1'b0, 1'b0, 1'b0, 1'b1};
    vec[3]  = '{1'b1, 1'b0, 24'h5A0304, 1'b0, 1'b0, 1'b0, 1'b1};
    vec[4]  = '{1'b1, 1'b0, 24'h5A0405, 1'b1, 1'b0, 1'b0, 1'b1};
    vec[5]  = '{1'b1, 1'b0, 24'h5A0506, 1'b1, 1'b0, 1'b1, 1'b1};  // dropped
    vec[6]  = '{1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b1, 1'b1};
    vec[7]  = '{1'b0, 1'b1, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b1};
    vec[8]  = '{1'b1, 1'b1, 24'h5A0809, 1'b1, 1'b0, 1'b1, 1'b1};  // set beats clear
    vec[9]  = '{1'b0, 1'b1, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b1};
    vec[10] = '{1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b1};

    b0.wr_en = 0; b0.wr_data = '0; b0.ldac_req = 0; b0.clr_ovf = 0;
    b1.wr_en = 0; b1.wr_data = '0; b1.ldac_req = 0; b1.clr_ovf = 0;

    // ---- reset state ----
    repeat (3) tick;
    smp;
    chk("rst_sync", b0.SYNC, 1);   chk("rst_sclk", b0.SCLK, 1);
    chk("rst_sdin", b0.SDIN, 0);   chk("rst_ldac", b0.LDAC, 1);
    chk("rst_full", b0.full, 0);   chk("rst_empty", b0.empty, 1);
    chk("rst_ovf", b0.overflow, 0); chk("rst_done", b0.frame_done, 0);
    chk("rst_busy", b0.busy, 0);
    tick; reset = 1'b0;

    // ---- flag table: back-to-back writes, overflow, clear ----
    rxq0.delete();
    for (int i = 0; i < 11; i++) begin
      tick;
      b0.wr_en = vec[i].wr; b0.clr_ovf = vec[i].clr; b0.wr_data = vec[i].d;
      smp;
      if (i > 0) begin
        chk($sformatf("vec%0d_full", i - 1), b0.full, vec[i-1].f);
        chk($sformatf("vec%0d_empty", i - 1), b0.empty, vec[i-1].e);
        chk($sformatf("vec%0d_ovf", i - 1), b0.overflow, vec[i-1].o);
        chk($sformatf("vec%0d_busy", i - 1), b0.busy, vec[i-1].b);
      end
    end
    tick; b0.wr_en = 0; b0.clr_ovf = 0;
    smp;
    chk("vec10_full", b0.full, vec[10].f);
    chk("vec10_ovf", b0.overflow, vec[10].o);
    wait_rx(0, 5, 5 * PERIOD0 + 50);
    for (int i = 0; i < 5 && i < rxq0.size(); i++)
      chk_frame($sformatf("b2b%0d", i), rxq0[i], vec[i].d, 98, (i > 0) ? 5 : 0);
    wait_idle0(20);
    chk("b2b_empty", b0.empty, 1);
    chk("b2b_noldac", ldac_falls[0], 0);

    // ---- single frame with write-to-SYNC latency ----
    rxq0.delete(); fd0 = fd_cnt[0];
    tick; b0.wr_en = 1; b0.wr_data = 24'hC08000;
    tick; b0.wr_en = 0;
    smp;
    chk("lat_sync_n1", b0.SYNC, 1);
    chk("lat_empty_n1", b0.empty, 0);
    smp;
    chk("lat_sync_n2", b0.SYNC, 0);
    wait_rx(0, 1, PERIOD0 + 20);
    if (rxq0.size() > 0) chk_frame("single", rxq0[0], 24'hC08000, 98, 0);
    chk("single_done_cnt", fd_cnt[0] - fd0, 1);
    chk("single_noldac", ldac_falls[0], 0);
    wait_idle0(20);

    // ---- LDAC after two frames, extra request merged ----
    rxq0.delete(); lf0 = ldac_falls[0];
    tick; b0.wr_en = 1; b0.wr_data = 24'h123456;
    tick; b0.wr_data = 24'hABCDEF;
    tick; b0.wr_en = 0; b0.ldac_req = 1;
    tick; b0.ldac_req = 0;
    begin
      int k = 0;
      while (b0.LDAC !== 1'b0 && k < 3 * PERIOD0) begin smp; k++; end
    end
    chk("ldac_fell", b0.LDAC, 0);
    chk("ldac_frames", rxq0.size(), 2);
    if (rxq0.size() == 2) begin
      chk_frame("ldf0", rxq0[0], 24'h123456, 98, 0);
      chk_frame("ldf1", rxq0[1], 24'hABCDEF, 98, 5);
    end
    chk("ldac_delay", ldac_dly[0], 5);
    chk("ldac_busy", b0.busy, 1);
    tick; b0.ldac_req = 1;
    tick; b0.ldac_req = 0;
    begin
      int k = 0;
      while (b0.LDAC !== 1'b1 && k < 20) begin smp; k++; end
    end
    chk("ldac_len", ldac_len[0], 3);
    smp;
    chk("ldac_busy_after", b0.busy, 0);
    repeat (30) smp;
    chk("ldac_pulses", ldac_falls[0] - lf0, 1);
    chk("ldac_sync_high", ldac_viol[0], 0);

    // ---- reset mid-shift ----
    rxq0.delete(); fd0 = fd_cnt[0];
    tick; b0.wr_en = 1; b0.wr_data = 24'h3C5AA5;
    tick; b0.wr_en = 0;
    begin
      int k = 0;
      while (!(b0.SYNC === 1'b0 && nb[0] == 10) && k < 200) begin smp; k++; end
    end
    chk("mid_falls", nb[0], 10);
    tick; reset = 1'b1;
    tick; reset = 1'b0;
    smp;
    chk("mid_sync", b0.SYNC, 1);  chk("mid_sclk", b0.SCLK, 1);
    chk("mid_sdin", b0.SDIN, 0);  chk("mid_empty", b0.empty, 1);
    chk("mid_done", b0.frame_done, 0); chk("mid_busy", b0.busy, 0);
    repeat (5) smp;
    chk("mid_partial", (rxq0.size() == 1) ? rxq0[0].nb : -1, 10);
    chk("mid_done_cnt", fd_cnt[0] - fd0, 0);

    // ---- divider sweep on the fast instance ----
    rxq1.delete();
    tick; b1.wr_en = 1; b1.wr_data = 24'hFFFFFF;
    tick; b1.wr_data = 24'h000001;
    tick; b1.wr_en = 0;
    wait_rx(1, 2, 200);
    if (rxq1.size() == 2) begin
      chk_frame("div0", rxq1[0], 24'hFFFFFF, 49, 0);
      chk_frame("div1", rxq1[1], 24'h000001, 49, 2);
    end

    // ---- random traffic against an occupancy model ----
    rxq0.delete(); mcnt = 0; idle_at = 0; movf = 0; burst = 0;
    for (int c = 0; c < 1500; c++) begin
      bit w, pop, mfull, mempty;
      logic [23:0] d;
      tick;
      if (burst == 0 && $urandom_range(0, 149) == 0) burst = $urandom_range(3, 7);
      w = (burst > 0) || ($urandom_range(0, 39) == 0);
      if (burst > 0) burst--;
      d = 24'($urandom);
      b0.wr_en = w; b0.wr_data = d;
      mfull  = (mcnt == 4);
      mempty = (mcnt == 0);
      pop    = (c >= idle_at) && (mcnt > 0);
      if (w && !mfull) expq.push_back(d);
      if (w && mfull) movf = 1;
      mcnt = mcnt + ((w && !mfull) ? 1 : 0) - (pop ? 1 : 0);
      if (pop) idle_at = c + PERIOD0;
      smp;
      chk("rnd_full", b0.full, mfull);
      chk("rnd_empty", b0.empty, mempty);
    end
    tick; b0.wr_en = 0;
    wait_rx(0, expq.size(), 6 * PERIOD0 + 50);
    for (int i = 0; i < expq.size() && i < rxq0.size(); i++) begin
      chk($sformatf("rnd%0d_data", i), rxq0[i].data, expq[i]);
      chk($sformatf("rnd%0d_falls", i), rxq0[i].nb, 24);
    end
    chk("rnd_ovf", b0.overflow, movf);
    wait_idle0(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
